// File: rtl/uart_gesture_reporter.sv
// Gesture event queue plus ASCII line formatter driving an 8N1 serializer.
// Define CONF_HEX_EN to append " XX" (confidence in hex) before CRLF.
module uart_gesture_tx #(
  parameter int CPB = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CPB - 1);

  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [8:0]    sh_q;
  logic          tx_q;
  logic          busy_q;

  // bit_q counts finished bit periods: 0 start, 1..8 data, 9 stop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (valid_i) begin
        sh_q   <= {1'b1, data_i};
        tx_q   <= 1'b0;
        busy_q <= 1'b1;
        cnt_q  <= '0;
        bit_q  <= '0;
      end
    end else if (cnt_q != CMAX) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        tx_q  <= sh_q[0];
        sh_q  <= {1'b1, sh_q[8:1]};
        bit_q <= bit_q + 4'd1;
      end
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
endmodule

module uart_gesture_reporter #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int NUM_CLASSES = 4,
  parameter int CLASS_W     = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CLASS_W-1:0]          gesture_class,
  input  logic                        gesture_valid,
  input  logic [7:0]                  gesture_confidence,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int NW  = CLASS_W + 1;
`ifdef CONF_HEX_EN
  localparam int FW = CLASS_W + 8;
  localparam logic [3:0] EXTRA = 4'd3;
`else
  localparam int FW = CLASS_W;
  localparam logic [3:0] EXTRA = 4'd0;
`endif
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [NW-1:0] NCLS = NW'(NUM_CLASSES);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_SEND, S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;
  logic [7:0]    drop_q;

  logic [CLASS_W-1:0] cls_q, cls_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         len_q, len_d;
  logic [7:0]         byte_q, byte_d;
  logic [7:0]         msg_byte;

  logic               in_rng, full, pop, push;
  logic [FW-1:0]      wdata, rdata;
  logic [CLASS_W-1:0] rcls;
  logic [2:0]         c3;
  logic [3:0]         tl;
  logic               tx_valid, ser_busy;

  function automatic logic [3:0] text_len(input logic [2:0] c);
    case (c)
      3'd1, 3'd2: return 4'd4;
      3'd3:       return 4'd5;
      default:    return 4'd2;
    endcase
  endfunction

  function automatic logic [7:0] txt_char(
    input logic [2:0] c,
    input logic [3:0] i
  );
    logic [39:0] s;
    case (c)
      3'd0:    s = {"UP", 24'h0};
      3'd1:    s = {"DOWN", 8'h0};
      3'd2:    s = {"LEFT", 8'h0};
      3'd3:    s = "RIGHT";
      default: s = {"G", 5'b00110, c, 24'h0};
    endcase
    s = s << {i, 3'b000};
    return s[39:32];
  endfunction

  assign in_rng = {1'b0, gesture_class} < NCLS;
  assign full   = lvl_q == FULL;
  assign pop    = state_q == S_POP;
  assign push   = gesture_valid && in_rng && (!full || pop);
  assign rdata  = mem_q[rp_q];
  assign rcls   = rdata[FW-1 -: CLASS_W];

`ifdef CONF_HEX_EN
  logic [7:0] conf_q, conf_d;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction

  assign wdata = {gesture_class, gesture_confidence};
`else
  logic unused_conf;
  assign unused_conf = ^gesture_confidence;
  assign wdata = gesture_class;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: ;
      endcase
      if (gesture_valid && in_rng && full && !pop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  // Byte at idx: text, optional " XX", then CR LF
  assign c3 = 3'(cls_q);
  assign tl = text_len(c3);

  always_comb begin
    msg_byte = 8'h0A;
    if (idx_q < tl) msg_byte = txt_char(c3, idx_q);
`ifdef CONF_HEX_EN
    else if (idx_q == tl)         msg_byte = 8'h20;
    else if (idx_q == tl + 4'd1)  msg_byte = hex(conf_q[7:4]);
    else if (idx_q == tl + 4'd2)  msg_byte = hex(conf_q[3:0]);
`endif
    else if (idx_q == len_q - 4'd2) msg_byte = 8'h0D;
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    idx_d    = idx_q;
    len_d    = len_q;
    byte_d   = byte_q;
    tx_valid = 1'b0;
`ifdef CONF_HEX_EN
    conf_d   = conf_q;
`endif
    unique case (state_q)
      S_IDLE: if (lvl_q != '0) state_d = S_POP;
      S_POP: begin
        cls_d   = rcls;
`ifdef CONF_HEX_EN
        conf_d  = rdata[7:0];
`endif
        idx_d   = '0;
        len_d   = text_len(3'(rcls)) + 4'd2 + EXTRA;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        byte_d  = msg_byte;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!ser_busy) begin
          tx_valid = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ser_busy) begin
          if (idx_q == len_q - 4'd1) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
`ifdef CONF_HEX_EN
      conf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
`ifdef CONF_HEX_EN
      conf_q  <= conf_d;
`endif
    end
  end

  uart_gesture_tx #(.CPB(CPB)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .valid_i (tx_valid),
    .data_i  (byte_q),
    .tx_o    (uart_tx),
    .busy_o  (ser_busy)
  );

  assign busy       = (state_q != S_IDLE) || (lvl_q != '0) || ser_busy;
  assign fifo_level = lvl_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_uart_gesture_reporter.sv
// Scoreboard bench: two reporter instances, UART receivers pop expected bytes.
`timescale 1ns/1ps
module tb_uart_gesture_reporter;
  localparam int CPB_A = 104;
  localparam int CPB_B = 10;
`ifdef CONF_HEX_EN
  localparam int XB = 3;
`else
  localparam int XB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [2:0] cls_a, cls_b;
  logic       vld_a, vld_b;
  logic [7:0] conf_a, conf_b;
  logic       tx_a, tx_b, busy_a, busy_b;
  logic [2:0] lvl_a, lvl_b;
  logic [7:0] drop_a, drop_b;

  uart_gesture_reporter u_a (
    .clk(clk), .rst(rst_a),
    .gesture_class(cls_a), .gesture_valid(vld_a),
    .gesture_confidence(conf_a),
    .uart_tx(tx_a), .busy(busy_a),
    .fifo_level(lvl_a), .drop_count(drop_a)
  );

  uart_gesture_reporter #(
    .CLK_FREQ_HZ(1_152_000), .NUM_CLASSES(8)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .gesture_class(cls_b), .gesture_valid(vld_b),
    .gesture_confidence(conf_b),
    .uart_tx(tx_b), .busy(busy_b),
    .fifo_level(lvl_b), .drop_count(drop_b)
  );

  int errs = 0;
  int checks = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int rx_a = 0;
  bit skip_a = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic expect_msg(input bit b, input string txt, input string hx);
    logic [7:0] q[$];
    for (int i = 0; i < txt.len(); i++) q.push_back(txt[i]);
`ifdef CONF_HEX_EN
    q.push_back(8'h20);
    q.push_back(hx[0]);
    q.push_back(hx[1]);
`endif
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    foreach (q[i]) begin
      if (b) exp_b.push_back(q[i]);
      else   exp_a.push_back(q[i]);
    end
  endtask

  task automatic rx_frame(input bit b, output logic [7:0] d,
                          output logic stp);
    int cpb;
    cpb = b ? CPB_B : CPB_A;
    do @(negedge clk); while ((b ? tx_b : tx_a) !== 1'b0);
    repeat (cpb / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      d[i] = b ? tx_b : tx_a;
    end
    repeat (cpb) @(negedge clk);
    stp = b ? tx_b : tx_a;
  endtask

  initial forever begin : mon_a
    logic [7:0] d;
    logic s;
    rx_frame(1'b0, d, s);
    rx_a++;
    if (skip_a) skip_a = 1'b0;
    else if (exp_a.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL mon_a extra byte: got %02h expected none", d);
    end else begin
      chk("mon_a byte", d, exp_a.pop_front());
      chk("mon_a stop", s, 1);
    end
  end

  initial forever begin : mon_b
    logic [7:0] d;
    logic s;
    rx_frame(1'b1, d, s);
    if (exp_b.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL mon_b extra byte: got %02h expected none", d);
    end else begin
      chk("mon_b byte", d, exp_b.pop_front());
      chk("mon_b stop", s, 1);
    end
  end

  task automatic ev(input bit b, input logic [2:0] c, input logic [7:0] cf);
    @(negedge clk);
    if (b) begin
      vld_b = 1'b1; cls_b = c; conf_b = cf;
    end else begin
      vld_a = 1'b1; cls_a = c; conf_a = cf;
    end
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  task automatic wait_drain(input bit b, input int budget, input string nm);
    int n;
    n = 0;
    while (((b ? exp_b.size() : exp_a.size()) != 0 ||
            (b ? busy_b : busy_a)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < budget), 1);
  endtask

  initial begin : stim
    int lat, n, base, low, mx, bz;
    rst_a = 1'b1; rst_b = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0;
    cls_a = '0; cls_b = '0;
    conf_a = '0; conf_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst tx", tx_a, 1);
    chk("rst busy", busy_a, 0);
    chk("rst level", lvl_a, 0);
    chk("rst drops", drop_a, 0);
    chk("rst b tx", tx_b, 1);
    chk("rst b busy", busy_b, 0);

    // single UP at 104 clk/bit
    expect_msg(1'b0, "UP", "11");
    ev(1'b0, 3'd0, 8'h11);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tx_a == 1'b0) begin
        lat = k;
        break;
      end
    end
    chk("start latency 1..4", int'(lat >= 1 && lat <= 4), 1);
    chk("busy in msg", busy_a, 1);
    n = 0;
    while (busy_a && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("busy fall window",
        int'(n >= (4 + XB) * 1040 && n <= (4 + XB) * 1040 + 3 * (3 + XB)), 1);
    chk("single drops", drop_a, 0);
    chk("single level", lvl_a, 0);
    wait_drain(1'b0, 2000, "single drain");

    // out-of-range class ignored
    ev(1'b0, 3'd6, 8'h66);
    mx = 0; bz = 0; low = 0;
    repeat (40) begin
      @(negedge clk);
      if (lvl_a > mx) mx = lvl_a;
      if (busy_a) bz++;
      if (!tx_a) low++;
    end
    chk("ign level", mx, 0);
    chk("ign busy", bz, 0);
    chk("ign line", low, 0);
    chk("ign drops", drop_a, 0);

    // reset in the middle of byte 3 of DOWN
    base = rx_a;
    expect_msg(1'b0, "DOWN", "22");
    ev(1'b0, 3'd1, 8'h22);
    n = 0;
    while (rx_a < base + 2 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("two bytes before rst", int'(n < 6000), 1);
    n = 0;
    while (tx_a && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("byte3 started", int'(n < 300), 1);
    repeat (460) @(negedge clk);
    chk("byte3 d3 low", tx_a, 0);
    rst_a = 1'b1;
    skip_a = 1'b1;
    exp_a.delete();
    @(negedge clk);
    chk("mid rst tx", tx_a, 1);
    chk("mid rst busy", busy_a, 0);
    chk("mid rst level", lvl_a, 0);
    chk("mid rst drops", drop_a, 0);
    rst_a = 1'b0;
    low = 0;
    repeat (3000) begin
      @(negedge clk);
      if (!tx_a) low++;
    end
    chk("quiet after rst", low, 0);
    expect_msg(1'b0, "UP", "5A");
    ev(1'b0, 3'd0, 8'h5A);
    wait_drain(1'b0, 12000, "post-rst drain");

    // FIFO order, one idle cycle between pulses
    expect_msg(1'b1, "RIGHT", "C3");
    expect_msg(1'b1, "DOWN", "01");
    expect_msg(1'b1, "LEFT", "B2");
    expect_msg(1'b1, "UP", "F0");
    ev(1'b1, 3'd3, 8'hC3);
    ev(1'b1, 3'd1, 8'h01);
    ev(1'b1, 3'd2, 8'hB2);
    ev(1'b1, 3'd0, 8'hF0);
    wait_drain(1'b1, 9000, "order drain");
    chk("order drops", drop_b, 0);

    // six back-to-back: one popped, four queued, sixth dropped
    expect_msg(1'b1, "UP", "00");
    expect_msg(1'b1, "DOWN", "11");
    expect_msg(1'b1, "LEFT", "22");
    expect_msg(1'b1, "RIGHT", "33");
    expect_msg(1'b1, "G4", "44");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vld_b = 1'b1;
      cls_b = 3'(i);
      conf_b = 8'(i * 17);
    end
    @(negedge clk);
    vld_b = 1'b0;
    chk("burst drops", drop_b, 1);
    chk("burst level", lvl_b, 4);
    chk("burst busy", busy_b, 1);
    wait_drain(1'b1, 10000, "burst drain");
    chk("burst drops after", drop_b, 1);

    // G-classes and confidence extremes
    expect_msg(1'b1, "G6", "6E");
    expect_msg(1'b1, "LEFT", "A7");
    expect_msg(1'b1, "LEFT", "00");
    expect_msg(1'b1, "G7", "7F");
    ev(1'b1, 3'd6, 8'h6E);
    ev(1'b1, 3'd2, 8'hA7);
    ev(1'b1, 3'd2, 8'h00);
    ev(1'b1, 3'd7, 8'h7F);
    wait_drain(1'b1, 9000, "gclass drain");
    chk("gclass drops", drop_b, 1);
    chk("gclass level", lvl_b, 0);

    repeat (300) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
